// File: rtl/adder_cla_pipe.sv
// Pipelined N-bit adder/subtractor built from 4-bit carry-lookahead groups.
// Each stage resolves one slice of GROUPS_PER_STAGE groups, and all stages advance under one global enable.
module adder_cla_pipe #(
    parameter int WIDTH            = 32,
    parameter int GROUPS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             zero
);
    localparam int SLICE_W = 4 * ((GROUPS_PER_STAGE < 1) ? 1 : GROUPS_PER_STAGE);
    localparam int STAGES  = WIDTH / SLICE_W;

    if (GROUPS_PER_STAGE < 1 || WIDTH < SLICE_W || (WIDTH % SLICE_W) != 0) begin : g_param_check
        $error("adder_cla_pipe: WIDTH must be a non-zero multiple of 4*GROUPS_PER_STAGE");
    end

    // 4-bit lookahead group: returns {group carry-out, sum[3:0]}.
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic ci);
        logic [3:0] p, g, c;
        logic       grp_p, grp_g;
        p     = x ^ y;
        g     = x & y;
        c[0]  = ci;
        c[1]  = g[0] | (p[0] & ci);
        c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        grp_p = &p;
        grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        return {grp_g | (grp_p & ci), p ^ c};
    endfunction

    logic             advance;
    logic             out_valid_q, c_out_q, overflow_q, zero_q;
    logic [WIDTH-1:0] sum_q;

    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance && !rst;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO  = k * SLICE_W;
        localparam int OPW = WIDTH - LO;

        // Unresolved operand bits [WIDTH-1:LO] skew along with the pipeline.
        logic               v_q, c_q;
        logic [OPW-1:0]     a_q, b_q;
        logic [SLICE_W-1:0] slice_sum;
        logic               slice_cout;

        always_comb begin : slice_logic
            logic       carry;
            logic [4:0] r;
            // NOTE: blocking assignments here so the group carry ripples through the loop in order.
            carry     = c_q;
            r         = '0;
            slice_sum = '0;
            for (int g = 0; g < GROUPS_PER_STAGE; g++) begin
                r                  = cla4(a_q[4*g +: 4], b_q[4*g +: 4], carry);
                slice_sum[4*g +: 4] = r[3:0];
                carry              = r[4];
            end
            slice_cout = carry;
        end

        if (k == 0) begin : g_first
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q <= 1'b0;
                end else if (advance) begin
                    v_q <= in_valid;
                end
            end

            // NOTE: operand and partial-sum registers carry no reset; only valid bits and outputs need defined values.
            always_ff @(posedge clk) begin
                if (advance) begin
                    a_q <= a;
                    b_q <= sub ? ~b : b;
                    c_q <= sub | c_in;
                end
            end
        end else begin : g_next
            logic [LO-1:0] s_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q <= 1'b0;
                end else if (advance) begin
                    v_q <= g_stage[k-1].v_q;
                end
            end

            always_ff @(posedge clk) begin
                if (advance) begin
                    a_q <= g_stage[k-1].a_q[OPW+SLICE_W-1:SLICE_W];
                    b_q <= g_stage[k-1].b_q[OPW+SLICE_W-1:SLICE_W];
                    c_q <= g_stage[k-1].slice_cout;
                end
            end

            if (k == 1) begin : g_s1
                always_ff @(posedge clk) begin
                    if (advance) s_q <= g_stage[0].slice_sum;
                end
            end else begin : g_sn
                always_ff @(posedge clk) begin
                    if (advance) s_q <= {g_stage[k-1].slice_sum, g_stage[k-1].g_next.s_q};
                end
            end
        end

        if (k == STAGES - 1) begin : g_last
            logic [WIDTH-1:0] sum_d;
            logic             overflow_d;

            if (k == 0) begin : g_sum_one
                assign sum_d = slice_sum;
            end else begin : g_sum_many
                assign sum_d = {slice_sum, g_next.s_q};
            end

            // Carry into the MSB equals a^b^sum at that bit.
            assign overflow_d = a_q[SLICE_W-1] ^ b_q[SLICE_W-1] ^ slice_sum[SLICE_W-1] ^ slice_cout;

            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid_q <= 1'b0;
                    sum_q       <= '0;
                    c_out_q     <= 1'b0;
                    overflow_q  <= 1'b0;
                    zero_q      <= 1'b0;
                end else if (advance) begin
                    out_valid_q <= v_q;
                    if (v_q) begin
                        sum_q      <= sum_d;
                        c_out_q    <= slice_cout;
                        overflow_q <= overflow_d;
                        zero_q     <= (sum_d == '0);
                    end
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_adder_cla_pipe.sv
// Self-checking bench for adder_cla_pipe: a 32-bit/2-group and an 8-bit/1-group instance.
// Directed table vectors, flow/stall/reset sequences, and randomized traffic against an arithmetic scoreboard.
module tb_adder_cla_pipe;
    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready, c_in, sub;
    logic [31:0] a, b;
    bit          narrow;

    always #5 clk = ~clk;

    logic        iv32, iv8;
    logic [7:0]  a8, b8;
    assign iv32 = in_valid && !narrow;
    assign iv8  = in_valid && narrow;
    assign a8   = a[7:0];
    assign b8   = b[7:0];

    logic        ir32, ov32, co32, of32, z32;
    logic [31:0] sum32;
    logic        ir8, ov8, co8, of8, z8;
    logic [7:0]  sum8;

    adder_cla_pipe #(.WIDTH(32), .GROUPS_PER_STAGE(2)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a), .b(b),
        .c_in(c_in), .sub(sub), .out_valid(ov32), .out_ready(out_ready),
        .sum(sum32), .c_out(co32), .overflow(of32), .zero(z32)
    );

    adder_cla_pipe #(.WIDTH(8), .GROUPS_PER_STAGE(1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .c_in(c_in), .sub(sub), .out_valid(ov8), .out_ready(out_ready),
        .sum(sum8), .c_out(co8), .overflow(of8), .zero(z8)
    );

    // Outputs of whichever instance is currently selected.
    logic        c_ir, c_ov, c_co, c_of, c_z;
    logic [31:0] c_sum;
    always_comb begin
        c_ir  = narrow ? ir8 : ir32;
        c_ov  = narrow ? ov8 : ov32;
        c_co  = narrow ? co8 : co32;
        c_of  = narrow ? of8 : of32;
        c_z   = narrow ? z8  : z32;
        c_sum = narrow ? {24'd0, sum8} : sum32;
    end

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    typedef struct {
        string       name;
        bit          narrow;
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic        sub;
        logic [31:0] e_sum;
        logic        e_co;
        logic        e_ov;
        logic        e_z;
    } vec_t;

    res_t        q32[$], q8[$];
    int          acc_edge[$], del_cyc[$];
    logic [31:0] del_sum[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain modular arithmetic on w-bit operands.
    function automatic res_t model(input logic [31:0] x, input logic [31:0] y,
                                   input logic ci, input logic s, input int w);
        logic [63:0] mask, ua, ub, t;
        res_t        r;
        mask   = (64'd1 << w) - 64'd1;
        ua     = {32'd0, x} & mask;
        ub     = {32'd0, (s ? ~y : y)} & mask;
        t      = ua + ub + ((s || ci) ? 64'd1 : 64'd0);
        r.sum  = 32'(t & mask);
        r.cout = t[w];
        r.ovf  = (ua[w-1] == ub[w-1]) && (t[w-1] != ua[w-1]);
        r.zero = ((t & mask) == 64'd0);
        return r;
    endfunction

    // Scoreboard: inputs pushed on accepting edges, results popped on output transfers.
    always @(negedge clk) begin
        res_t e;
        if (rst) begin
            q32.delete();
            q8.delete();
        end else begin
            if (iv32 && ir32) begin
                q32.push_back(model(a, b, c_in, sub, 32));
                acc_edge.push_back(cyc + 1);
            end
            if (ov32 && out_ready) begin
                if (q32.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb32_unexpected: got sum 0x%0h expected no output", sum32);
                end else begin
                    e = q32.pop_front();
                    check("sb32_sum", sum32, e.sum);
                    check("sb32_cout", co32, e.cout);
                    check("sb32_ovf", of32, e.ovf);
                    check("sb32_zero", z32, e.zero);
                end
                del_cyc.push_back(cyc);
                del_sum.push_back(sum32);
            end
            if (iv8 && ir8) q8.push_back(model(a, b, c_in, sub, 8));
            if (ov8 && out_ready) begin
                if (q8.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb8_unexpected: got sum 0x%0h expected no output", sum8);
                end else begin
                    e = q8.pop_front();
                    check("sb8_sum", {24'd0, sum8}, e.sum);
                    check("sb8_cout", co8, e.cout);
                    check("sb8_ovf", of8, e.ovf);
                    check("sb8_zero", z8, e.zero);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic clear_logs();
        acc_edge.delete();
        del_cyc.delete();
        del_sum.delete();
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        int lat;
        lat       = v.narrow ? 2 : 4;
        narrow    = v.narrow;
        a         = v.a;
        b         = v.b;
        c_in      = v.ci;
        sub       = v.sub;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check({v.name, "_in_ready"}, c_ir, 1);
        tick();
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        n        = 0;
        while (!c_ov && n < 20) begin
            tick();
            n++;
        end
        check({v.name, "_latency"}, n, lat);
        check({v.name, "_sum"}, c_sum, v.e_sum);
        check({v.name, "_cout"}, c_co, v.e_co);
        check({v.name, "_ovf"}, c_of, v.e_ov);
        check({v.name, "_zero"}, c_z, v.e_z);
        tick();
    endtask

    task automatic random_run(input bit nar, input int n);
        narrow = nar;
        for (int i = 0; i < n; i++) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            a         = pick();
            b         = pick();
            c_in      = 1'($urandom);
            sub       = 1'($urandom);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (12) tick();
        check(nar ? "rand8_drained" : "rand32_drained", nar ? q8.size() : q32.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[12];
        logic [31:0] held_sum;
        logic        held_co, held_of, held_z;

        vecs[0]  = '{"add_wrap",     0, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0, 32'h0000_0000, 1, 0, 1};
        vecs[1]  = '{"add_posovf",   0, 32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 32'h8000_0000, 0, 1, 0};
        vecs[2]  = '{"add_negovf",   0, 32'h8000_0000, 32'h8000_0000, 0, 0, 32'h0000_0000, 1, 1, 1};
        vecs[3]  = '{"sub_borrow",   0, 32'h0000_0005, 32'h0000_0007, 1, 1, 32'hFFFF_FFFE, 0, 0, 0};
        vecs[4]  = '{"sub_noborrow", 0, 32'h0000_0007, 32'h0000_0005, 1, 1, 32'h0000_0002, 1, 0, 0};
        vecs[5]  = '{"sub_zero",     0, 32'h0000_0000, 32'h0000_0000, 0, 1, 32'h0000_0000, 1, 0, 1};
        vecs[6]  = '{"sub_minovf",   0, 32'h8000_0000, 32'h0000_0001, 0, 1, 32'h7FFF_FFFF, 1, 1, 0};
        vecs[7]  = '{"add_slicecy",  0, 32'h0000_FFFF, 32'h0000_0001, 0, 0, 32'h0001_0000, 0, 0, 0};
        vecs[8]  = '{"n_add_wrap",   1, 32'h0000_00FF, 32'h0000_0001, 0, 0, 32'h0000_0000, 1, 0, 1};
        vecs[9]  = '{"n_add_ovf",    1, 32'h0000_007F, 32'h0000_0001, 0, 0, 32'h0000_0080, 0, 1, 0};
        vecs[10] = '{"n_sub_borrow", 1, 32'h0000_0003, 32'h0000_0005, 1, 1, 32'h0000_00FE, 0, 0, 0};
        vecs[11] = '{"n_sub_ovf",    1, 32'h0000_0080, 32'h0000_0001, 0, 1, 32'h0000_007F, 1, 1, 0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c_in = 1'b0; sub = 1'b0; narrow = 1'b0;

        // Reset state on both instances.
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid32", ov32, 0);
        check("rst_sum32", sum32, 0);
        check("rst_flags32", {co32, of32, z32}, 0);
        check("rst_in_ready32", ir32, 0);
        check("rst_out_valid8", ov8, 0);
        check("rst_sum8", sum8, 0);
        check("rst_flags8", {co8, of8, z8}, 0);
        check("rst_in_ready8", ir8, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed vectors; the first is accepted on the first edge with rst low.
        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Eight back-to-back transfers.
        narrow = 1'b0; out_ready = 1'b1; clear_logs();
        for (int i = 0; i < 8; i++) begin
            a = i; b = 32'h0FFF_FFFF; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        repeat (8) tick();
        check("b2b_count", del_cyc.size(), 8);
        if (del_cyc.size() == 8 && acc_edge.size() == 8) begin
            for (int j = 0; j < 8; j++) begin
                check($sformatf("b2b_sum%0d", j), del_sum[j], 32'h0FFF_FFFF + j);
                check($sformatf("b2b_cycle%0d", j), del_cyc[j], acc_edge[0] + 4 + j);
            end
        end

        // A single input gap gives a single output gap.
        clear_logs();
        for (int i = 0; i < 9; i++) begin
            a = $urandom; b = $urandom; c_in = 1'($urandom); sub = 1'($urandom);
            in_valid = (i != 3);
            tick();
        end
        in_valid = 1'b0;
        repeat (8) tick();
        check("gap_count", del_cyc.size(), 8);
        if (del_cyc.size() == 8 && acc_edge.size() == 8) begin
            for (int j = 0; j < 8; j++)
                check($sformatf("gap_latency%0d", j), del_cyc[j] - acc_edge[j], 4);
            check("gap_single", del_cyc[3] - del_cyc[2], 2);
        end

        // Full pipeline stalled for three cycles, then released.
        clear_logs();
        for (int i = 0; i < 6; i++) begin
            a = pick(); b = pick(); c_in = 1'($urandom); sub = 1'($urandom); in_valid = 1'b1;
            tick();
        end
        out_ready = 1'b0;
        held_sum = '0; held_co = 1'b0; held_of = 1'b0; held_z = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check($sformatf("stall_in_ready%0d", s), ir32, 0);
            check($sformatf("stall_out_valid%0d", s), ov32, 1);
            if (s == 0) begin
                held_sum = sum32; held_co = co32; held_of = of32; held_z = z32;
            end else begin
                check($sformatf("stall_sum%0d", s), sum32, held_sum);
                check($sformatf("stall_flags%0d", s), {co32, of32, z32}, {held_co, held_of, held_z});
            end
            tick();
            a = $urandom; b = $urandom;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = pick(); b = pick(); c_in = 1'($urandom); sub = 1'($urandom); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        repeat (10) tick();
        check("stall_delivered", del_cyc.size(), acc_edge.size());
        check("stall_drained", q32.size(), 0);

        // Reset with three transactions in flight.
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            a = $urandom; b = $urandom; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("rstfl_in_ready", ir32, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rstfl_out_valid", ov32, 0);
        repeat (10) tick();
        check("rstfl_none_emerge", del_cyc.size(), 0);

        // Reset during a stall has priority over hold.
        for (int i = 0; i < 6; i++) begin
            a = $urandom; b = $urandom; in_valid = 1'b1;
            tick();
        end
        out_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0; clear_logs();
        @(negedge clk);
        check("rststall_out_valid", ov32, 0);
        check("rststall_in_ready", ir32, 1);
        out_ready = 1'b1;
        repeat (10) tick();
        check("rststall_none_emerge", del_cyc.size(), 0);

        // Randomized traffic with backpressure on both widths.
        random_run(1'b0, 400);
        random_run(1'b1, 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
